// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state type and constants for the data-RAM arbiter
package dmem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arbState_t;

    localparam int AW_DEF   = 10;
    localparam int DW_DEF   = 16;
    localparam int PORT_CPU = 0;
    localparam int PORT_DMA = 1;

endpackage

// File: rtl/dmem_rr_pick.sv
// rtl/dmem_rr_pick.sv - combinational two-way selector; ptr picks the winner when both request
module dmem_rr_pick
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = 2'b00;
            if (ptr) gnt[PORT_DMA] = 1'b1;
            else     gnt[PORT_CPU] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter for the single-port data RAM with CPU lock
// DMEM_ARB_CPU_PRIORITY_EN: fixed CPU priority instead of round-robin
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic          lock0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          lock_err
);

    arbState_t     state, stateNext;
    logic [7:0]    lockCnt, lockCntNext;
    logic          favourDma, favourDmaNext;
    logic          lockErrQ, lockErrNext;
    logic [1:0]    pick, grant;
    logic          rvalid0Q, rvalid1Q;
    logic [DW-1:0] hold0, hold1;

    // favourDma is the round-robin pointer, or the post-overrun DMA flag in priority mode
    dmem_rr_pick uPick (
        .req ({req1, req0}),
        .ptr (favourDma),
        .gnt (pick)
    );

    always_comb begin
        stateNext     = state;
        lockCntNext   = lockCnt;
        favourDmaNext = favourDma;
        lockErrNext   = 1'b0;
        grant         = 2'b00;
        if (reset) begin
            case (state)
                IDLE: begin
                    grant = pick;
`ifdef DMEM_ARB_CPU_PRIORITY_EN
                    if (grant[PORT_DMA]) favourDmaNext = 1'b0;
`else
                    if (grant != 2'b00) favourDmaNext = grant[PORT_CPU];
`endif
                    if (grant[PORT_CPU] && lock0) begin
                        if (LOCK_MAX <= 1) begin
                            lockErrNext   = 1'b1;
                            favourDmaNext = 1'b1;
                        end else begin
                            stateNext   = LOCKED;
                            lockCntNext = 8'd1;
                        end
                    end
                end
                LOCKED: begin
                    grant[PORT_CPU] = req0;
                    if (!lock0) begin
                        stateNext   = IDLE;
                        lockCntNext = 8'd0;
                    end else if (int'(lockCnt) + 1 >= LOCK_MAX) begin
                        stateNext     = IDLE;
                        lockCntNext   = 8'd0;
                        lockErrNext   = 1'b1;
                        favourDmaNext = 1'b1;
                    end else begin
                        lockCntNext = lockCnt + 8'd1;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lockCnt   <= 8'd0;
            favourDma <= 1'b0;
            lockErrQ  <= 1'b0;
            rvalid0Q  <= 1'b0;
            rvalid1Q  <= 1'b0;
            hold0     <= '0;
            hold1     <= '0;
        end else begin
            state     <= stateNext;
            lockCnt   <= lockCntNext;
            favourDma <= favourDmaNext;
            lockErrQ  <= lockErrNext;
            rvalid0Q  <= grant[PORT_CPU] & ~we0;
            rvalid1Q  <= grant[PORT_DMA] & ~we1;
            if (rvalid0Q) hold0 <= ram_rdata;
            if (rvalid1Q) hold1 <= ram_rdata;
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        if (grant[PORT_CPU]) begin
            ram_addr  = addr0;
            ram_wdata = wdata0;
        end else if (grant[PORT_DMA]) begin
            ram_addr  = addr1;
            ram_wdata = wdata1;
        end
    end

    assign gnt0     = grant[PORT_CPU];
    assign gnt1     = grant[PORT_DMA];
    assign ram_we   = (grant[PORT_CPU] & we0) | (grant[PORT_DMA] & we1);
    assign lock_err = lockErrQ;
    // RAM data arrives in the return cycle itself; the hold registers keep it afterwards
    assign rvalid0  = rvalid0Q;
    assign rvalid1  = rvalid1Q;
    assign rdata0   = rvalid0Q ? ram_rdata : hold0;
    assign rdata1   = rvalid1Q ? ram_rdata : hold1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter against a behavioural model
module tb_dmem_arbiter;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int LOCK_MAX = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, we0, lock0, gnt0, rvalid0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0, rdata0;
    logic          req1, we1, gnt1, rvalid1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1, rdata1;
    logic          ram_we, lock_err;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .lock_err(lock_err)
    );

    // Synchronous RAM with a bench-side preload port
    logic [DW-1:0] ramArr [1<<AW];
    logic          ldEn;
    logic [AW-1:0] ldAddr;
    logic [DW-1:0] ldData;
    always @(posedge clk) begin
        if (ldEn) ramArr[ldAddr] <= ldData;
        else if (ram_we) ramArr[ram_addr] <= ram_wdata;
        ram_rdata <= ramArr[ram_addr];
    end

    logic [DW-1:0] shadow [1<<AW];
    bit            mLocked, mFavour, mErr;
    int            mRun;
    bit            mPend [2];
    logic [DW-1:0] mPendData [2];
    logic [DW-1:0] mHold [2];
    logic          eG0, eG1, eWe, eRv0, eRv1, eErr;
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eWd, eRd0, eRd1;
    int            nPass = 0;
    int            nTotal = 0;

    task automatic model_reset();
        mLocked = 0; mFavour = 0; mErr = 0; mRun = 0;
        for (int p = 0; p < 2; p++) begin
            mPend[p] = 0; mPendData[p] = '0; mHold[p] = '0;
        end
    endtask

    task automatic predict();
        if (mLocked) begin
            eG0 = req0; eG1 = 1'b0;
        end else if (req0 && req1) begin
            eG0 = !mFavour; eG1 = mFavour;
        end else begin
            eG0 = req0; eG1 = req1;
        end
        eWe   = (eG0 && we0) || (eG1 && we1);
        eAddr = eG0 ? addr0 : (eG1 ? addr1 : {AW{1'b0}});
        eWd   = eG0 ? wdata0 : (eG1 ? wdata1 : {DW{1'b0}});
        eRv0  = mPend[0];
        eRd0  = mPend[0] ? mPendData[0] : mHold[0];
        eRv1  = mPend[1];
        eRd1  = mPend[1] ? mPendData[1] : mHold[1];
        eErr  = mErr;
    endtask

    task automatic commit();
        for (int p = 0; p < 2; p++) if (mPend[p]) mHold[p] = mPendData[p];
        mPend[0] = eG0 && !we0; mPendData[0] = shadow[addr0];
        mPend[1] = eG1 && !we1; mPendData[1] = shadow[addr1];
        if (eWe) shadow[eAddr] = eWd;
        mErr = 0;
        if (mLocked) begin
            if (!lock0) mLocked = 0;
            else begin
                mRun++;
                if (mRun >= LOCK_MAX) begin mLocked = 0; mErr = 1; mFavour = 1; end
            end
        end else if (eG0 || eG1) begin
`ifdef DMEM_ARB_CPU_PRIORITY_EN
            if (eG1) mFavour = 0;
`else
            mFavour = eG0;
`endif
            if (eG0 && lock0) begin
                mRun = 1;
                if (mRun >= LOCK_MAX) begin mErr = 1; mFavour = 1; end
                else mLocked = 1;
            end
        end
    endtask

    function automatic logic [63:0] act_vec();
        return {gnt0, gnt1, ram_we, ram_addr, ram_wdata, rvalid0, rdata0, rvalid1, rdata1, lock_err};
    endfunction

    function automatic logic [63:0] exp_vec();
        return {eG0, eG1, eWe, eAddr, eWd, eRv0, eRd0, eRv1, eRd1, eErr};
    endfunction

    task automatic settle();
        @(negedge clk);
        predict();
    endtask

    task automatic advance();
        commit();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic r, input logic w, input logic l, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
    endtask

    task automatic drive1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1 = r; we1 = w; addr1 = a; wdata1 = d;
    endtask

    task automatic idle_cycles(input int n);
        drive0(0, 0, 0, '0, '0);
        drive1(0, 0, '0, '0);
        repeat (n) begin settle(); advance(); end
    endtask

    // One lone DMA grant leaves the CPU favoured for the next contention
    task automatic prime();
        idle_cycles(2);
        drive1(1, 0, AW'($urandom), '0);
        settle(); advance();
        idle_cycles(1);
    endtask

    task automatic test_reset();
        drive0(1, 0, 1, 10'h123, '0);
        drive1(1, 0, 10'h200, '0);
        settle();
        nTotal++; if (gnt0 !== 1'b1) $display("FAIL reset_pre_gnt0 got %b want 1", gnt0); else nPass++;
        advance();
        reset = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            nTotal++;
            if ({gnt0, gnt1, rvalid0, rvalid1, lock_err, ram_we} !== 6'b0)
                $display("FAIL reset_outputs got %b want 000000", {gnt0, gnt1, rvalid0, rvalid1, lock_err, ram_we});
            else nPass++;
            nTotal++; if (rdata0 !== '0) $display("FAIL reset_rdata0 got %h want 0000", rdata0); else nPass++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        lock0 = 1'b0;
        settle();
        nTotal++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL reset_first_contention got %b want 10", {gnt0, gnt1}); else nPass++;
        nTotal++; if (act_vec() !== exp_vec()) $display("FAIL reset_release_vec got %h want %h", act_vec(), exp_vec()); else nPass++;
        advance();
        drive0(0, 0, 0, '0, '0);
        settle();
        nTotal++; if (act_vec() !== exp_vec()) $display("FAIL reset_after_vec got %h want %h", act_vec(), exp_vec()); else nPass++;
        advance();
        idle_cycles(2);
    endtask

    task automatic test_read();
        idle_cycles(1);
        ldEn = 1'b1; ldAddr = 10'h005; ldData = 16'h1234; shadow[5] = 16'h1234;
        settle(); advance();
        ldEn = 1'b0;
        drive0(1, 0, 0, 10'h005, '0);
        settle();
        nTotal++; if (gnt0 !== 1'b1) $display("FAIL read_gnt0 got %b want 1", gnt0); else nPass++;
        nTotal++; if (ram_addr !== 10'h005) $display("FAIL read_ram_addr got %h want 005", ram_addr); else nPass++;
        nTotal++; if (ram_we !== 1'b0) $display("FAIL read_ram_we got %b want 0", ram_we); else nPass++;
        advance();
        drive0(0, 0, 0, '0, '0);
        settle();
        nTotal++; if (rvalid0 !== 1'b1) $display("FAIL read_rvalid0 got %b want 1", rvalid0); else nPass++;
        nTotal++; if (rdata0 !== 16'h1234) $display("FAIL read_rdata0 got %h want 1234", rdata0); else nPass++;
        advance();
        settle();
        nTotal++; if (rvalid0 !== 1'b0) $display("FAIL read_rvalid0_drop got %b want 0", rvalid0); else nPass++;
        nTotal++; if (rdata0 !== 16'h1234) $display("FAIL read_rdata0_hold got %h want 1234", rdata0); else nPass++;
        advance();
    endtask

`ifndef DMEM_ARB_CPU_PRIORITY_EN
    task automatic test_alternate();
        logic [DW-1:0] d0, d1;
        prime();
        d0 = DW'($urandom); d1 = DW'($urandom);
        for (int c = 0; c < 4; c++) begin
            drive0(1, 1, 0, 10'h010, d0);
            drive1(1, 1, 10'h3FF, d1);
            settle();
            nTotal++;
            if ({gnt0, gnt1} !== ((c % 2 == 0) ? 2'b10 : 2'b01))
                $display("FAIL alt_gnt c=%0d got %b want %b", c, {gnt0, gnt1}, (c % 2 == 0) ? 2'b10 : 2'b01);
            else nPass++;
            nTotal++; if (ram_we !== 1'b1) $display("FAIL alt_ram_we c=%0d got %b want 1", c, ram_we); else nPass++;
            nTotal++;
            if (ram_addr !== ((c % 2 == 0) ? 10'h010 : 10'h3FF))
                $display("FAIL alt_ram_addr c=%0d got %h want %h", c, ram_addr, (c % 2 == 0) ? 10'h010 : 10'h3FF);
            else nPass++;
            nTotal++; if (act_vec() !== exp_vec()) $display("FAIL alt_vec c=%0d got %h want %h", c, act_vec(), exp_vec()); else nPass++;
            if (eG0) d0 = DW'($urandom);
            if (eG1) d1 = DW'($urandom);
            advance();
        end
        idle_cycles(1);
    endtask
`else
    task automatic test_priority();
        prime();
        for (int c = 0; c < 4; c++) begin
            drive0(1, 0, 0, AW'($urandom), '0);
            drive1(1, 0, AW'($urandom), '0);
            settle();
            nTotal++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL prio_gnt c=%0d got %b want 10", c, {gnt0, gnt1}); else nPass++;
            nTotal++; if (act_vec() !== exp_vec()) $display("FAIL prio_vec c=%0d got %h want %h", c, act_vec(), exp_vec()); else nPass++;
            advance();
        end
        idle_cycles(1);
    endtask
`endif

    task automatic test_lock_hold();
        prime();
        drive1(1, 0, 10'h0AA, '0);
        for (int c = 0; c < 3; c++) begin
            drive0(1, 1, 1, AW'(10'h040 + c), DW'($urandom));
            settle();
            nTotal++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL lock_hold c=%0d got %b want 10", c, {gnt0, gnt1}); else nPass++;
            nTotal++; if (act_vec() !== exp_vec()) $display("FAIL lock_hold_vec c=%0d got %h want %h", c, act_vec(), exp_vec()); else nPass++;
            advance();
        end
        drive0(0, 0, 0, '0, '0);
        settle();
        nTotal++; if ({gnt0, gnt1} !== 2'b00) $display("FAIL lock_drop_cycle got %b want 00", {gnt0, gnt1}); else nPass++;
        advance();
        settle();
        nTotal++; if (gnt1 !== 1'b1) $display("FAIL lock_after_gnt1 got %b want 1", gnt1); else nPass++;
        nTotal++; if (act_vec() !== exp_vec()) $display("FAIL lock_after_vec got %h want %h", act_vec(), exp_vec()); else nPass++;
        advance();
        idle_cycles(2);
    endtask

    task automatic test_lock_overrun();
        int   errCnt, errCyc;
        logic gnt1AtErr;
        errCnt = 0; errCyc = 0; gnt1AtErr = 1'b0;
        prime();
        drive1(1, 0, 10'h155, '0);
        for (int c = 1; c <= 12; c++) begin
            drive0(1, 1, 1, AW'($urandom), DW'($urandom));
            settle();
            nTotal++; if (act_vec() !== exp_vec()) $display("FAIL overrun_vec c=%0d got %h want %h", c, act_vec(), exp_vec()); else nPass++;
            if (lock_err === 1'b1) begin errCnt++; errCyc = c; gnt1AtErr = gnt1; end
            advance();
        end
        nTotal++; if (errCnt !== 1) $display("FAIL overrun_pulses got %0d want 1", errCnt); else nPass++;
        nTotal++; if (errCyc !== 9) $display("FAIL overrun_pulse_cycle got %0d want 9", errCyc); else nPass++;
        nTotal++; if (gnt1AtErr !== 1'b1) $display("FAIL overrun_dma_grant got %b want 1", gnt1AtErr); else nPass++;
        idle_cycles(2);
    endtask

    task automatic test_random();
        bit            p0, p1;
        logic          w0, w1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        int            lockPct;
        p0 = 0; p1 = 0; w0 = 0; w1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int c = 0; c < 400; c++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1; w0 = 1'($urandom_range(0, 1)); a0 = AW'($urandom_range(0, 15)); d0 = DW'($urandom);
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1; w1 = 1'($urandom_range(0, 1)); a1 = AW'($urandom_range(0, 15)); d1 = DW'($urandom);
            end
            lockPct = ((c / 50) % 2 == 1) ? 95 : 25;
            drive0(p0, w0, $urandom_range(0, 99) < lockPct, a0, d0);
            drive1(p1, w1, a1, d1);
            settle();
            nTotal++; if (act_vec() !== exp_vec()) $display("FAIL random_vec c=%0d got %h want %h", c, act_vec(), exp_vec()); else nPass++;
            if (eG0) p0 = 0;
            if (eG1) p1 = 0;
            advance();
        end
        idle_cycles(2);
    endtask

    initial begin
        reset = 1'b0;
        ldEn = 1'b0; ldAddr = '0; ldData = '0;
        drive0(0, 0, 0, '0, '0);
        drive1(0, 0, '0, '0);
        model_reset();
        @(posedge clk); #1;
        for (int i = 0; i < (1 << AW); i++) begin
            ldEn = 1'b1; ldAddr = AW'(i); ldData = DW'($urandom); shadow[i] = ldData;
            @(posedge clk); #1;
        end
        ldEn = 1'b0;
        reset = 1'b1;
        test_reset();
        test_read();
`ifndef DMEM_ARB_CPU_PRIORITY_EN
        test_alternate();
`else
        test_priority();
`endif
        test_lock_hold();
        test_lock_overrun();
        test_random();
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 1024x16 data RAM between two requesters: the CPU datapath (port 0) and the DMA/debug loader (port 1).
- Grants one access per cycle using round-robin.
- Supports a lock so the CPU can hold the RAM across multi-cycle stack or read-modify-write sequences.
- Sits between the datapath's dataAddress/writeData/WE/readData pins and the data RAM.

Parameters:
- AW, 10, address width in words.
- DW, 16, data width.
- LOCK_MAX, 8, maximum consecutive cycles a lock may hold the RAM before it is forcibly released (range 1..255).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 (CPU) access request.
- we0  in  1  port 0 write enable; 0 = read.
- lock0  in  1  port 0 requests to keep the grant on following cycles.
- addr0  in  AW  port 0 word address.
- wdata0  in  DW  port 0 write data.
- gnt0  out  1  port 0 access accepted this cycle.
- rvalid0  out  1  port 0 read data valid.
- rdata0  out  DW  port 0 read data.
- req1, we1, addr1, wdata1  in  1/1/AW/DW  port 1 equivalents; port 1 has no lock.
- gnt1, rvalid1, rdata1  out  1/1/DW  port 1 equivalents.
- ram_we  out  1  RAM write strobe.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data, valid one cycle after the address.
- lock_err  out  1  one-cycle pulse when a lock is force-released.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; rr_ptr=0 (port 0 favoured); lock counter=0.
  - Outputs rvalid0/1=0, lock_err=0, rdata0/1=0.
  - gnt0/1=0 and ram_we=0 while reset is low.
- Grant is combinational from req inputs and registered state. An accepted access is presented to the RAM in the same cycle as gnt:
  - ram_addr/ram_wdata = addrN/wdataN.
  - ram_we = weN & gntN.
- With no grant: ram_we=0, ram_addr=0, ram_wdata=0.
- At most one of gnt0/gnt1 is high in any cycle.
- Read latency: a read granted in cycle N gives rvalidN=1 and rdataN=ram_rdata in cycle N+1, registered. rdataN holds its value until the next read on that port completes.
- Writes produce no rvalid.
- States:
  - IDLE:
    - Only one req high: grant it.
    - Both high: grant the port selected by rr_ptr.
    - After any grant: rr_ptr <= other port.
    - Port 0 granted with lock0=1: go to LOCKED, lock counter=1.
  - LOCKED:
    - Only port 0 may be granted; gnt1=0 even if req1=1. gnt0 = req0.
    - Each cycle with lock0=1: counter increments.
    - lock0=0: return to IDLE next cycle. The current cycle's req0 is still granted.
    - Counter reaches LOCK_MAX with lock0 still high: pulse lock_err for one cycle, go to IDLE, rr_ptr <= 1 so port 1 wins the next contention. The cycle in which the counter reaches LOCK_MAX is still granted to port 0.
- Requesters hold req, we, addr and wdata stable until they see gnt. A request dropped before grant is discarded with no side effects.
- Simultaneous events:
  - req0 with lock0 against req1 in IDLE with rr_ptr=1: port 1 wins; the lock takes effect only when port 0 is next granted.
- Asynchronous reset in LOCKED or with a read pending: the pending rvalid is lost, the state returns to IDLE, and no lock_err is raised.

Optional Feature:
- Macro DMEM_ARB_CPU_PRIORITY_EN.
- Defined: fixed priority replaces round-robin. In IDLE port 0 always wins contention and rr_ptr is unused (held at 0). Lock and LOCK_MAX behaviour are unchanged, and a forced release still grants port 1 on the next contended cycle.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package dmem_pkg:
  - state enum (IDLE, LOCKED).
  - constants AW_DEF=10, DW_DEF=16.
  - port index constants PORT_CPU=0, PORT_DMA=1.
- One natural sub-module: dmem_rr_pick. It is the combinational two-way round-robin selector: inputs req[1:0] and ptr; outputs a one-hot grant.
- The FSM, lock counter and read-return registers stay in dmem_arbiter.

Test Plan:
- Reset low mid-stream, then release: gnt0=gnt1=rvalid0=rvalid1=lock_err=0 during reset. After release, first contention grants port 0.
- req0 read addr 0x005 with RAM word 0x1234: gnt0 in cycle N; rvalid0=1 and rdata0=0x1234 in N+1.
- req0 and req1 both high continuously, both writing: grants alternate 0,1,0,1. ram_we=1 each cycle with ram_addr switching between addr0=0x010 and addr1=0x3FF.
- Lock hold: lock0=1 with req0 for 3 cycles while req1 is held high. gnt1=0 for those cycles, gnt0=1 throughout, and gnt1=1 on the first cycle after lock0 drops.
- Lock overrun with LOCK_MAX=8: lock0 and req0 held 12 cycles. lock_err pulses once, after the 8th granted cycle. The next cycle grants port 1 (req1 high); no second pulse occurs.
- With DMEM_ARB_CPU_PRIORITY_EN defined: both requests high for 4 cycles -> gnt0 all 4 cycles, gnt1 0 all 4 cycles.
